mio_bus_arbiter: RTL and testbench

//  Shares one memory/IO bus between the CPU data port and a DMA requester.

---
 rtl/mio_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_mio_bus_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_arbiter.sv
// rtl/mio_bus_arbiter.sv - CPU/DMA round-robin memory bus arbiter with slave timeout
module mio_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_ready_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  output logic [31:0] dma_rdata_o,
  output logic        dma_ready_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        bus_err_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS_CPU, BUS_DMA, RESP} state_e;

  state_e        state_q, state_d;
  logic          last_dma_q, last_dma_d;
  logic          owner_dma_q, owner_dma_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   dma_rdata_q, dma_rdata_d;
  logic          bus_err_q, bus_err_d;

  always_comb begin
    state_d     = state_q;
    last_dma_d  = last_dma_q;
    owner_dma_d = owner_dma_q;
    cnt_d       = cnt_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    bus_err_d   = bus_err_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // On a tie the CPU wins only if the DMA had the previous grant
        if (cpu_req_i && (!dma_req_i || last_dma_q)) begin
          owner_dma_d = 1'b0;
          mem_we_d    = cpu_we_i;
          mem_addr_d  = cpu_addr_i;
          mem_wdata_d = cpu_wdata_i;
          state_d     = BUS_CPU;
        end else if (dma_req_i) begin
          owner_dma_d = 1'b1;
          mem_we_d    = dma_we_i;
          mem_addr_d  = dma_addr_i;
          mem_wdata_d = dma_wdata_i;
          state_d     = BUS_DMA;
        end
      end
      BUS_CPU, BUS_DMA: begin
        if (mem_ack_i) begin
          if (!mem_we_q) begin
            if (owner_dma_q) dma_rdata_d = mem_rdata_i;
            else             cpu_rdata_d = mem_rdata_i;
          end
          state_d = RESP;
        end else if (cnt_q == CNT_MAX) begin
          if (owner_dma_q) dma_rdata_d = ERR_DATA;
          else             cpu_rdata_d = ERR_DATA;
          bus_err_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        last_dma_d = owner_dma_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      last_dma_q  <= 1'b1;
      owner_dma_q <= 1'b0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      owner_dma_q <= owner_dma_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req_o   = (state_q == BUS_CPU) || (state_q == BUS_DMA);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign cpu_ready_o = (state_q == RESP) && !owner_dma_q;
  assign dma_ready_o = (state_q == RESP) && owner_dma_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb/tb_mio_bus_arbiter.sv - directed self-checking bench for mio_bus_arbiter
module tb_mio_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we, mem_ack;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_ready, dma_ready, mem_req, mem_we, bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mio_bus_arbiter #(.TIMEOUT(64), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk), .reset_i(reset),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wdata_i(dma_wdata),
    .dma_rdata_o(dma_rdata), .dma_ready_o(dma_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack), .bus_err_o(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic seen;

    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    tick(); tick();
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_cpu_ready", 32'(cpu_ready), 0);
    check("rst_dma_ready", 32'(dma_ready), 0);
    check("rst_bus_err", 32'(bus_err), 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    tick();

    // 1: CPU read, ack two cycles after mem_req rises; address must stay latched
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0010;
    tick();
    check("t1_mem_req_c1", 32'(mem_req), 1);
    check("t1_mem_addr_c1", mem_addr, 32'h0000_0010);
    check("t1_mem_we", 32'(mem_we), 0);
    cpu_addr = 32'h0000_FFFF;
    tick();
    check("t1_mem_addr_c2", mem_addr, 32'h0000_0010);
    check("t1_no_ready_c2", 32'(cpu_ready), 0);
    tick();
    check("t1_mem_req_c3", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 0; mem_rdata = 0; cpu_req = 0;
    check("t1_cpu_ready", 32'(cpu_ready), 1);
    check("t1_dma_ready", 32'(dma_ready), 0);
    check("t1_cpu_rdata", cpu_rdata, 32'h1234_5678);
    check("t1_mem_req_resp", 32'(mem_req), 0);
    tick();
    check("t1_ready_one_pulse", 32'(cpu_ready), 0);

    // 2: simultaneous requests after reset alternate CPU, DMA, CPU, DMA
    reset = 1; tick(); reset = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0A00;
    dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0B00;
    for (int g = 0; g < 4; g++) begin
      tick();
      check($sformatf("t2_grant%0d_addr", g), mem_addr, (g % 2 == 0) ? 32'h0000_0A00 : 32'h0000_0B00);
      mem_ack = 1; mem_rdata = 32'h5000_0000 + 32'(g);
      tick();
      mem_ack = 0;
      check($sformatf("t2_grant%0d_cpu_ready", g), 32'(cpu_ready), (g % 2 == 0) ? 1 : 0);
      check($sformatf("t2_grant%0d_dma_ready", g), 32'(dma_ready), (g % 2 == 0) ? 0 : 1);
      tick();
    end
    check("t2_cpu_rdata", cpu_rdata, 32'h5000_0002);
    check("t2_dma_rdata", dma_rdata, 32'h5000_0003);
    cpu_req = 0; dma_req = 0;

    // 3: DMA zero-wait write; read data must not be disturbed
    dma_req = 1; dma_we = 1; dma_addr = 32'h0000_0100; dma_wdata = 32'hA5A5_A5A5;
    tick();
    check("t3_mem_req", 32'(mem_req), 1);
    check("t3_mem_we", 32'(mem_we), 1);
    check("t3_mem_addr", mem_addr, 32'h0000_0100);
    check("t3_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    mem_ack = 1; mem_rdata = 32'hFFFF_0000;
    tick();
    mem_ack = 0; dma_req = 0; dma_we = 0;
    check("t3_dma_ready_n2", 32'(dma_ready), 1);
    check("t3_cpu_ready", 32'(cpu_ready), 0);
    check("t3_dma_rdata_kept", dma_rdata, 32'h5000_0003);
    tick();

    // 4: CPU read to a silent slave times out after 64 bus cycles
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0040;
    n = 0; seen = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (mem_req) n++;
      if (cpu_ready) begin
        seen = 1;
        break;
      end
    end
    cpu_req = 0;
    check("t4_ready_seen", 32'(seen), 1);
    check("t4_mem_req_cycles", 32'(n), 64);
    check("t4_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("t4_bus_err", 32'(bus_err), 1);
    tick();
    cpu_req = 1;
    tick();
    mem_ack = 1; mem_rdata = 32'h0000_7777;
    tick();
    mem_ack = 0; cpu_req = 0;
    check("t4_next_read", cpu_rdata, 32'h0000_7777);
    check("t4_bus_err_sticky", 32'(bus_err), 1);
    tick();

    // 5: reset during a DMA transfer, ack arrives one cycle late
    dma_req = 1; dma_we = 0; dma_addr = 32'h0000_0200;
    tick();
    check("t5_mem_req_before", 32'(mem_req), 1);
    reset = 1; dma_req = 0;
    tick();
    reset = 0; mem_ack = 1; mem_rdata = 32'h0BAD_0BAD;
    check("t5_mem_req_after_rst", 32'(mem_req), 0);
    check("t5_bus_err_cleared", 32'(bus_err), 0);
    check("t5_no_dma_ready", 32'(dma_ready), 0);
    tick();
    mem_ack = 0;
    check("t5_late_ack_ready", 32'(dma_ready), 0);
    check("t5_late_ack_rdata", dma_rdata, 0);
    check("t5_late_ack_mem_req", 32'(mem_req), 0);
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_0020;
    tick();
    check("t5_cpu_mem_addr", mem_addr, 32'h0000_0020);
    mem_ack = 1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ack = 0; cpu_req = 0;
    check("t5_cpu_ready", 32'(cpu_ready), 1);
    check("t5_cpu_rdata", cpu_rdata, 32'hCAFE_0001);

    // 6: stray acks in RESP and IDLE change nothing
    mem_ack = 1; mem_rdata = 32'hBAD0_BAD0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t6_cpu_ready_%0d", k), 32'(cpu_ready), 0);
      check($sformatf("t6_dma_ready_%0d", k), 32'(dma_ready), 0);
      check($sformatf("t6_cpu_rdata_%0d", k), cpu_rdata, 32'hCAFE_0001);
      check($sformatf("t6_mem_req_%0d", k), 32'(mem_req), 0);
    end
    check("t6_dma_rdata", dma_rdata, 0);
    mem_ack = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
